// File: rtl/axi_lite_core_ctrl.sv
`default_nettype none
// ==========================================================================================
// axi_lite_core_ctrl: AXI4-Lite control slave (run FSM, instr loader); option CORE_CTRL_IRQ_EN
// Rev 1.0
// ==========================================================================================
module axi_lite_core_ctrl #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5,
  parameter int NUM_CYCLE_BIT        = 32,
  parameter int IMEM_ADDR_WIDTH      = 10
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              o_running,
  output logic                              o_done,
  output logic                              o_mem_reset_n,
  output logic                              o_instr_wr,
  output logic [IMEM_ADDR_WIDTH-1:0]        o_instr_addr,
  output logic [31:0]                       o_instr_data,
  output logic                              o_irq
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_NUM    = 3'd2;
  localparam logic [2:0] REG_CNT    = 3'd3;
  localparam logic [2:0] REG_IADDR  = 3'd4;
  localparam logic [2:0] REG_IDATA  = 3'd5;
  localparam logic [2:0] REG_IRQ    = 3'd6;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [NUM_CYCLE_BIT-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  logic clk;
  logic rst_n;
  assign clk   = s00_axi_aclk;
  assign rst_n = s00_axi_aresetn;

  state_t                     state;
  state_t                     state_next;
  logic [NUM_CYCLE_BIT-1:0]   num_cycle;
  logic [NUM_CYCLE_BIT-1:0]   run_len;
  logic [NUM_CYCLE_BIT-1:0]   cycle_cnt;
  logic [IMEM_ADDR_WIDTH-1:0] imem_ptr;
  logic                       mem_rst;
  logic                       done_sticky;
  logic                       aborted_sticky;
  logic [31:0]                rd_mux;

  logic       wr_en;
  logic       rd_en;
  logic [2:0] wr_idx;
  logic [2:0] rd_idx;
  logic       ctrl_wr;
  logic       run_req;
  logic       abort_req;
  logic       imem_sel;
  logic       imem_reject;
  logic       imem_load;

  assign wr_en  = s00_axi_awready & s00_axi_awvalid & s00_axi_wready & s00_axi_wvalid;
  assign rd_en  = s00_axi_arready & s00_axi_arvalid;
  assign wr_idx = s00_axi_awaddr[4:2];
  assign rd_idx = s00_axi_araddr[4:2];

  assign ctrl_wr     = wr_en && (wr_idx == REG_CTRL) && s00_axi_wstrb[0];
  assign run_req     = ctrl_wr && s00_axi_wdata[0];
  assign abort_req   = ctrl_wr && s00_axi_wdata[2];
  assign imem_sel    = wr_en && (wr_idx == REG_IDATA);
  assign imem_reject = imem_sel && ((s00_axi_wstrb != 4'hF) || (state == ST_RUNNING));
  assign imem_load   = imem_sel && !imem_reject;

  // Write channel: ready pulses once per accepted beat, response holds until bready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= RESP_OKAY;
    end else begin
      s00_axi_awready <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !s00_axi_awready;
      s00_axi_wready  <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !s00_axi_awready;
      if (wr_en) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= imem_reject ? RESP_SLVERR : RESP_OKAY;
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_arready <= s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready;
      if (rd_en) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_mux;
      end else if (s00_axi_rvalid && s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  assign s00_axi_rresp = RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (run_req) begin
          state_next = (num_cycle == '0) ? ST_DONE : ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else if (cycle_cnt == run_len - NUM_CYCLE_BIT'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The abort cycle still counts, so CYCLE_CNT equals the cycles o_running was high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len        <= '0;
      cycle_cnt      <= '0;
      done_sticky    <= 1'b0;
      aborted_sticky <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run_req) begin
            run_len        <= num_cycle;
            cycle_cnt      <= '0;
            done_sticky    <= 1'b0;
            aborted_sticky <= 1'b0;
          end
        end
        ST_RUNNING: begin
          if (cycle_cnt != CNT_MAX) begin
            cycle_cnt <= cycle_cnt + NUM_CYCLE_BIT'(1);
          end
          if (abort_req) begin
            aborted_sticky <= 1'b1;
          end
        end
        ST_DONE: done_sticky <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rst      <= 1'b0;
      num_cycle    <= '0;
      imem_ptr     <= '0;
      o_instr_wr   <= 1'b0;
      o_instr_addr <= '0;
      o_instr_data <= '0;
    end else begin
      o_instr_wr <= imem_load;
      if (imem_load) begin
        o_instr_addr <= imem_ptr;
        o_instr_data <= s00_axi_wdata;
        imem_ptr     <= imem_ptr + IMEM_ADDR_WIDTH'(1);
      end
      if (ctrl_wr) begin
        mem_rst <= s00_axi_wdata[1];
      end
      if (wr_en && (wr_idx == REG_NUM)) begin
        num_cycle <= NUM_CYCLE_BIT'(merge_strb(32'(num_cycle), s00_axi_wdata, s00_axi_wstrb));
      end
      if (wr_en && (wr_idx == REG_IADDR)) begin
        imem_ptr <= IMEM_ADDR_WIDTH'(merge_strb(32'(imem_ptr), s00_axi_wdata, s00_axi_wstrb));
      end
    end
  end

`ifdef CORE_CTRL_IRQ_EN
  logic irq_pending;
  logic irq_enable;

  // The DONE-cycle set is placed last so it overrides a coincident W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pending <= 1'b0;
      irq_enable  <= 1'b0;
    end else begin
      if (wr_en && (wr_idx == REG_IRQ) && s00_axi_wstrb[0]) begin
        irq_enable <= s00_axi_wdata[1];
        if (s00_axi_wdata[0]) begin
          irq_pending <= 1'b0;
        end
      end
      if (state == ST_DONE) begin
        irq_pending <= 1'b1;
      end
    end
  end

  assign o_irq = irq_pending & irq_enable;
`else
  assign o_irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      REG_CTRL:   rd_mux[1] = mem_rst;
      REG_STATUS: rd_mux[3:0] = {aborted_sticky, done_sticky,
                                 state == ST_RUNNING, state == ST_IDLE};
      REG_NUM:    rd_mux = 32'(num_cycle);
      REG_CNT:    rd_mux = 32'(cycle_cnt);
      REG_IADDR:  rd_mux = 32'(imem_ptr);
`ifdef CORE_CTRL_IRQ_EN
      REG_IRQ:    rd_mux[1:0] = {irq_enable, irq_pending};
`else
      REG_IRQ:    rd_mux = '0;
`endif
      default:    rd_mux = '0;
    endcase
  end

  assign o_running     = (state == ST_RUNNING);
  assign o_done        = (state == ST_DONE);
  assign o_mem_reset_n = ~mem_rst;

  logic unused_sigs;
  assign unused_sigs = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_core_ctrl.sv
`default_nettype none
// ==========================================================================================
// tb_axi_lite_core_ctrl: table-driven register vectors plus run/abort/IRQ/handshake sequences
// Rev 1.0
// ==========================================================================================
module tb_axi_lite_core_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        running;
  logic        done;
  logic        mem_reset_n;
  logic        instr_wr;
  logic [9:0]  instr_addr;
  logic [31:0] instr_data;
  logic        irq;

  axi_lite_core_ctrl dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .o_running(running), .o_done(done),
    .o_mem_reset_n(mem_reset_n), .o_instr_wr(instr_wr), .o_instr_addr(instr_addr),
    .o_instr_data(instr_data), .o_irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Output monitor: counts of running/done cycles and a log of instruction strobes.
  int          run_cycles = 0;
  int          done_cycles = 0;
  logic [41:0] instr_log[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (running) run_cycles++;
      if (done) done_cycles++;
      if (instr_wr) instr_log.push_back({instr_addr, instr_data});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    resp = 2'b11;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 50);
    if (!awready) begin
      awvalid = 1'b0; wvalid = 1'b0;
      timeout("aw_handshake");
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin
      timeout("b_response");
      return;
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    d = 32'hBAD0BAD0;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 50);
    if (!arready) begin
      arvalid = 1'b0;
      timeout("ar_handshake");
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      timeout("r_response");
      return;
    end
    d = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic run_and_check(input int n, input string tag);
    logic [1:0]  r;
    logic [31:0] d;
    int r0, d0;
    axi_write(5'h08, n, 4'hF, r);
    r0 = run_cycles; d0 = done_cycles;
    axi_write(5'h00, 32'h1, 4'hF, r);
    repeat (n + 8) @(posedge clk);
    #1;
    check({tag, "_running_cycles"}, run_cycles - r0, n);
    check({tag, "_done_pulses"}, done_cycles - d0, 1);
    axi_read(5'h04, d); check({tag, "_status"}, d, 32'h5);
    axi_read(5'h0C, d); check({tag, "_cycle_cnt"}, d, n);
  endtask

  typedef struct {
    logic        is_rd;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;      // rdata for reads, bresp for writes
    logic        exp_mrn;  // o_mem_reset_n after the access
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs[NVEC];

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [31:0] d2;
    logic [41:0] exp_log[3];
    int r0, d0, n, aw_seen, bv_held;

    vecs[0]  = '{1'b1, 5'h00, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[1]  = '{1'b1, 5'h04, 32'h0,        4'h0, 32'h1,        1'b1};
    vecs[2]  = '{1'b1, 5'h08, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[3]  = '{1'b1, 5'h0C, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[4]  = '{1'b1, 5'h10, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 5'h14, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 5'h18, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 5'h1C, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 5'h08, 32'hDEADBEEF, 4'h5, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 5'h08, 32'h0,        4'h0, 32'h00AD00EF, 1'b1};
    vecs[10] = '{1'b0, 5'h1C, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 5'h1C, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 5'h00, 32'h2,        4'hF, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 5'h00, 32'h0,        4'h0, 32'h2,        1'b0};
    vecs[14] = '{1'b0, 5'h00, 32'h4,        4'hF, 32'h0,        1'b1};
    vecs[15] = '{1'b1, 5'h04, 32'h0,        4'h0, 32'h1,        1'b1};
    vecs[16] = '{1'b0, 5'h10, 32'h3FE,      4'hF, 32'h0,        1'b1};
    vecs[17] = '{1'b0, 5'h14, 32'hA,        4'hF, 32'h0,        1'b1};
    vecs[18] = '{1'b0, 5'h14, 32'hB,        4'hF, 32'h0,        1'b1};
    vecs[19] = '{1'b0, 5'h14, 32'hC,        4'hF, 32'h0,        1'b1};
    vecs[20] = '{1'b1, 5'h10, 32'h0,        4'h0, 32'h1,        1'b1};
    vecs[21] = '{1'b0, 5'h14, 32'h55,       4'h3, 32'h2,        1'b1};
    vecs[22] = '{1'b1, 5'h10, 32'h0,        4'h0, 32'h1,        1'b1};
    vecs[23] = '{1'b1, 5'h14, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[24] = '{1'b0, 5'h00, 32'h2,        4'h2, 32'h0,        1'b1};
    vecs[25] = '{1'b1, 5'h00, 32'h0,        4'h0, 32'h0,        1'b1};
    exp_log[0] = {10'h3FE, 32'hA};
    exp_log[1] = {10'h3FF, 32'hB};
    exp_log[2] = {10'h000, 32'hC};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mem_reset_n", mem_reset_n, 1);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_instr_wr", instr_wr, 0);
    check("rst_irq", irq, 0);
    check("rst_bvalid_rvalid", {bvalid, rvalid}, 0);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_rd) begin
        axi_read(vecs[i].addr, d);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp);
      end
      check($sformatf("vec%0d_mem_reset_n", i), mem_reset_n, vecs[i].exp_mrn);
    end

    check("instr_strobe_count", instr_log.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("instr_strobe%0d", i), (instr_log.size() > i) ? instr_log[i] : '1, exp_log[i]);

    run_and_check(5, "run5");

    // Long run: redundant RUN, loader write while running, then ABORT.
    axi_write(5'h08, 32'd100, 4'hF, resp);
    r0 = run_cycles; d0 = done_cycles;
    axi_write(5'h00, 32'h1, 4'hF, resp);
    axi_write(5'h00, 32'h1, 4'hF, resp);
    axi_write(5'h14, 32'h123, 4'hF, resp);
    check("imem_wr_running_bresp", resp, 2'b10);
    n = 0;
    while (run_cycles - r0 < 8 && n < 200) begin @(posedge clk); #1; n++; end
    axi_write(5'h00, 32'h4, 4'hF, resp);
    check("abort_running_dropped", running, 0);
    repeat (3) @(posedge clk); #1;
    check("abort_no_done", done_cycles - d0, 0);
    check("abort_run_short", (run_cycles - r0 > 8) && (run_cycles - r0 < 100), 1);
    axi_read(5'h04, d); check("abort_status", d, 32'h9);
    axi_read(5'h0C, d); check("abort_cycle_cnt", d, run_cycles - r0);
    check("instr_strobe_count_after_run", instr_log.size(), 3);
    axi_read(5'h10, d); check("imem_ptr_unchanged", d, 32'h1);

    run_and_check(1, "run1");

`ifdef CORE_CTRL_IRQ_EN
    axi_write(5'h18, 32'h2, 4'hF, resp);
    check("irq_enable_bresp", resp, 2'b00);
    check("irq_low_before_done", irq, 0);
`endif
    run_and_check(0, "run0");
`ifdef CORE_CTRL_IRQ_EN
    check("irq_after_done", irq, 1);
    axi_read(5'h18, d); check("irq_reg_pending", d, 32'h3);
    axi_write(5'h18, 32'h3, 4'hF, resp);
    check("irq_after_w1c", irq, 0);
    axi_read(5'h18, d); check("irq_reg_cleared", d, 32'h2);
`else
    check("irq_tied_low", irq, 0);
    axi_write(5'h18, 32'h3, 4'hF, resp);
    check("irq_reg_write_bresp", resp, 2'b00);
    axi_read(5'h18, d); check("irq_reg_reads_zero", d, 32'h0);
`endif

    // Read and write to NUM_CYCLE in the same cycle: read sees the old value.
    fork
      axi_write(5'h08, 32'h7, 4'hF, resp);
      axi_read(5'h08, d2);
    join
    check("simul_read_old", d2, 32'h0);
    axi_read(5'h08, d); check("simul_write_applied", d, 32'h7);

    // Response back-pressure: no new acceptance while bvalid is held.
    awaddr = 5'h08; wdata = 32'h8; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 50);
    if (!awready) timeout("hold_first_aw");
    @(posedge clk); #1;
    wdata = 32'h9;
    aw_seen = 0; bv_held = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (awready) aw_seen++;
      if (bvalid) bv_held++;
    end
    check("hold_no_awready", aw_seen, 0);
    check("hold_bvalid", bv_held, 20);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    if (!awready) timeout("hold_second_aw");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("hold_second_bresp", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(5'h08, d); check("hold_second_data", d, 32'h9);

    // Asynchronous reset with a run in progress and a response outstanding.
    axi_write(5'h00, 32'h3, 4'hF, resp);
    awaddr = 5'h10; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_reset_state", {bvalid, running, mem_reset_n}, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bvalid, running, mem_reset_n, instr_wr}, 4'b0010);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(5'h04, d); check("post_reset_status", d, 32'h1);
    axi_read(5'h08, d); check("post_reset_num", d, 32'h0);
    axi_read(5'h10, d); check("post_reset_imem_ptr", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
